// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg -- shared fetch-stage types, reset PC and redirect encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Bit positions inside redirect_type, shared with the EX-stage branch unit
  localparam int unsigned RT_BTYPE = 0;
  localparam int unsigned RT_JALR  = 1;
  localparam int unsigned RT_JAL   = 2;
  localparam int unsigned RT_AUIPC = 3;
  localparam int unsigned RT_WIDTH = 4;

  function automatic logic is_onehot(input logic [RT_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if -- redirect, instruction-memory and decode-side signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                redirect_valid;
  logic [RT_WIDTH-1:0] redirect_type;
  logic [31:0]         redirect_target;
  logic                imem_req;
  logic [31:0]         imem_addr;
  logic                imem_ready;
  logic                imem_rvalid;
  logic [31:0]         imem_rdata;
  logic                if_valid;
  logic [31:0]         if_pc;
  logic [31:0]         if_inst;
  logic                if_ready;
  logic                flush;
  logic                redirect_err;

  modport master (
    input  redirect_valid, redirect_type, redirect_target,
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output if_valid, if_pc, if_inst,
    input  if_ready,
    output flush, redirect_err
  );

  modport slave (
    output redirect_valid, redirect_type, redirect_target,
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  if_valid, if_pc, if_inst,
    output if_ready,
    input  flush, redirect_err
  );

endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit -- single-outstanding instruction fetch with one-entry buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_inflight_q, pc_inflight_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_inst_q, if_inst_d;
  logic         redirect_err_q, redirect_err_d;

  logic can_issue;
  logic accept;
  logic consume;
  logic bad_redirect;

  // A request only goes out when the buffer will have room for its response
  assign can_issue = (state_q == REQ) && (!if_valid_q || bus.if_ready)
                     && !bus.redirect_valid && !rst;
  assign accept    = can_issue && bus.imem_ready;
  assign consume   = if_valid_q && bus.if_ready;
  assign bad_redirect = bus.redirect_valid &&
                        (!is_onehot(bus.redirect_type) || (bus.redirect_target[1:0] != 2'b00));

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pc_inflight_d  = pc_inflight_q;
    if_valid_d     = if_valid_q;
    if_pc_d        = if_pc_q;
    if_inst_d      = if_inst_q;
    redirect_err_d = redirect_err_q || bad_redirect;

    if (consume) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (accept) begin
          pc_inflight_d = pc_q;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if_inst_d  = bus.imem_rdata;
          if_pc_d    = pc_inflight_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = REQ;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over every update above; a response arriving with it is discarded
    if (bus.redirect_valid) begin
      pc_d       = {bus.redirect_target[31:2], 2'b00};
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      case (state_q)
        WAIT:    state_d = bus.imem_rvalid ? REQ : DROP;
        // Leaving DROP on a coincident response keeps the FSM from waiting forever
        DROP:    state_d = bus.imem_rvalid ? REQ : DROP;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      pc_inflight_q  <= '0;
      if_valid_q     <= 1'b0;
      if_pc_q        <= '0;
      if_inst_q      <= '0;
      redirect_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_inflight_q  <= pc_inflight_d;
      if_valid_q     <= if_valid_d;
      if_pc_q        <= if_pc_d;
      if_inst_q      <= if_inst_d;
      redirect_err_q <= redirect_err_d;
    end
  end

  assign bus.imem_req     = can_issue;
  assign bus.imem_addr    = can_issue ? pc_q : 32'h0000_0000;
  assign bus.flush        = bus.redirect_valid && !rst;
  assign bus.if_valid     = if_valid_q;
  assign bus.if_pc        = if_pc_q;
  assign bus.if_inst      = if_inst_q;
  assign bus.redirect_err = redirect_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit -- cycle table for corner cases, then a scoreboarded stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [3:0]  rtype;
    logic [31:0] rtgt;
    logic        rdy;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ifr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_flush;
    logic        e_ifv;
    logic [31:0] e_ifpc;
    logic [31:0] e_inst;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  vec_t   vecs[$];
  fetch_t exp_q[$];

  fetch_unit_if bus_if ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic rv, input logic [3:0] rt, input logic [31:0] tgt,
    input logic rdy, input logic rvl, input logic [31:0] rd, input logic ifr,
    input logic req, input logic [31:0] addr, input logic fl, input logic ifv,
    input logic [31:0] ifpc, input logic [31:0] inst, input logic err);
    vec_t v;
    v.rst = r; v.rv = rv; v.rtype = rt; v.rtgt = tgt; v.rdy = rdy; v.rvalid = rvl;
    v.rdata = rd; v.ifr = ifr; v.e_req = req; v.e_addr = addr; v.e_flush = fl;
    v.e_ifv = ifv; v.e_ifpc = ifpc; v.e_inst = inst; v.e_err = err;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                    = v.rst;
    bus_if.redirect_valid  = v.rv;
    bus_if.redirect_type   = v.rtype;
    bus_if.redirect_target = v.rtgt;
    bus_if.imem_ready      = v.rdy;
    bus_if.imem_rvalid     = v.rvalid;
    bus_if.imem_rdata      = v.rdata;
    bus_if.if_ready        = v.ifr;
  endtask

  initial begin
    int          consumes;
    logic        pending;
    logic        next_pending;
    logic [31:0] pend_addr;
    logic [31:0] next_addr;
    logic [31:0] exp_pc;
    logic        rdy_now;
    logic        ifr_now;
    fetch_t      f;

    // rst  rv rtype  target        rdy rvl rdata         ifr | req addr          fl ifv ifpc          inst          err
    vecs.push_back(mk(1, 1, 4'b0011, 32'h102, 0, 0, 32'h0, 0,   0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 1, 32'h13, 0,  0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 1, 0, 32'h0, 0,   0, 32'h0, 0, 1, 32'h0, 32'h13, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'h4, 0, 1, 32'h0, 32'h13, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 1, 32'h93, 1,  0, 32'h0, 0, 0, 32'h0, 32'h13, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'h8, 0, 1, 32'h4, 32'h93, 0));
    // Redirect while the request to 8 is outstanding, then the stale response
    vecs.push_back(mk(0, 1, 4'b0100, 32'h100, 1, 0, 32'h0, 1,   0, 32'h0, 1, 0, 32'h4, 32'h93, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 1, 32'hDEAD, 1, 0, 32'h0, 0, 0, 32'h4, 32'h93, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'h100, 0, 0, 32'h4, 32'h93, 0));
    // Redirect coincident with the response
    vecs.push_back(mk(0, 1, 4'b0001, 32'h200, 1, 1, 32'hBEEF, 1, 0, 32'h0, 1, 0, 32'h4, 32'h93, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'h200, 0, 0, 32'h4, 32'h93, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 1, 32'h113, 1, 0, 32'h0, 0, 0, 32'h4, 32'h93, 0));
    // Malformed redirect in REQ: performed, suppresses the request, sets sticky error
    vecs.push_back(mk(0, 1, 4'b0011, 32'h102, 1, 0, 32'h0, 0,   0, 32'h0, 1, 1, 32'h200, 32'h113, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'h100, 0, 0, 32'h200, 32'h113, 1));
    // Redirect to the top word, then fetch and wrap
    vecs.push_back(mk(0, 1, 4'b1000, 32'hFFFF_FFFC, 1, 0, 32'h0, 1, 0, 32'h0, 1, 0, 32'h200, 32'h113, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 1, 32'hDEAD, 1, 0, 32'h0, 0, 0, 32'h200, 32'h113, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'hFFFF_FFFC, 0, 0, 32'h200, 32'h113, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 1, 32'h213, 1, 0, 32'h0, 0, 0, 32'h200, 32'h113, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'h0, 0, 1, 32'hFFFF_FFFC, 32'h213, 1));
    // Reset while a request is outstanding
    vecs.push_back(mk(1, 0, 4'b0000, 32'h0,   0, 0, 32'h0, 0,   0, 32'h0, 0, 0, 32'hFFFF_FFFC, 32'h213, 1));
    vecs.push_back(mk(1, 0, 4'b0000, 32'h0,   0, 0, 32'h0, 0,   0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   0, 0, 32'h0, 1,   0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   0, 0, 32'h0, 1,   1, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 0, 32'h0, 1,   1, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0,   1, 1, 32'h13, 0,  0, 32'h0, 0, 0, 32'h0, 32'h0, 0));

    drive(mk(1, 0, 4'b0000, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #4;
      chk($sformatf("v%0d.imem_req", i),     {31'b0, bus_if.imem_req},     {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d.imem_addr", i),    bus_if.imem_addr,             vecs[i].e_addr);
      chk($sformatf("v%0d.flush", i),        {31'b0, bus_if.flush},        {31'b0, vecs[i].e_flush});
      chk($sformatf("v%0d.if_valid", i),     {31'b0, bus_if.if_valid},     {31'b0, vecs[i].e_ifv});
      chk($sformatf("v%0d.if_pc", i),        bus_if.if_pc,                 vecs[i].e_ifpc);
      chk($sformatf("v%0d.if_inst", i),      bus_if.if_inst,               vecs[i].e_inst);
      chk($sformatf("v%0d.redirect_err", i), {31'b0, bus_if.redirect_err}, {31'b0, vecs[i].e_err});
      @(posedge clk);
      #1;
    end

    // Streaming phase: buffer already holds {pc 0, 0x13}, next fetch is pc 4
    exp_q.push_back('{pc: 32'h0, inst: mem_word(32'h0)});
    exp_pc   = 32'h4;
    pending  = 1'b0;
    pend_addr = 32'h0;
    consumes = 0;
    for (int c = 0; c < 60; c++) begin
      if (c < 30) begin
        rdy_now = ($urandom_range(0, 3) != 0);
        ifr_now = ($urandom_range(0, 2) != 0);
      end else begin
        rdy_now = 1'b1;
        ifr_now = 1'b1;
      end
      rst                    = 1'b0;
      bus_if.redirect_valid  = 1'b0;
      bus_if.redirect_type   = 4'b0000;
      bus_if.redirect_target = 32'h0;
      bus_if.imem_ready      = rdy_now;
      bus_if.imem_rvalid     = pending;
      bus_if.imem_rdata      = pending ? mem_word(pend_addr) : 32'h0;
      bus_if.if_ready        = ifr_now;
      #4;
      next_pending = 1'b0;
      next_addr    = 32'h0;
      if (bus_if.imem_req && rdy_now) begin
        chk($sformatf("s%0d.imem_addr", c), bus_if.imem_addr, exp_pc);
        exp_q.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
        next_pending = 1'b1;
        next_addr    = exp_pc;
        exp_pc       = exp_pc + 32'd4;
      end
      if (bus_if.if_valid && ifr_now) begin
        if (c >= 34 && c < 54) consumes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL s%0d.unexpected_inst: got pc %h, scoreboard empty", c, bus_if.if_pc);
        end else begin
          f = exp_q.pop_front();
          chk($sformatf("s%0d.if_pc", c),   bus_if.if_pc,   f.pc);
          chk($sformatf("s%0d.if_inst", c), bus_if.if_inst, f.inst);
        end
      end
      @(posedge clk);
      #1;
      pending   = next_pending;
      pend_addr = next_addr;
    end
    chk("throughput_20cyc", consumes, 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
